// File: rtl/fas_pkg.sv
// Shared types and constants for the frequency-analysis chain:
// the serial-to-parallel stage, the FFT core and the parallel-to-serial unloader.
package fas_pkg;

    localparam int FAS_N     = 16;
    localparam int FAS_IDX_W = 4;
    localparam int FAS_DW    = 32;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } fas_cplx_t;

    typedef enum logic {
        PTS_IDLE,
        PTS_STREAM
    } pts_state_t;

    function automatic logic [FAS_IDX_W-1:0] fas_bitrev4(input logic [FAS_IDX_W-1:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/fft_frame_pts_if.sv
// Bundle of the parallel frame input, the serial valid/ready output and status flags.
// slave is the unloader's view, master is the view of whoever drives and consumes it.
interface fft_frame_pts_if;
    import fas_pkg::*;

    logic                 fft_valid;
    logic [FAS_DW-1:0]    fft_d [FAS_N];
    logic                 out_ready;
    logic                 out_valid;
    logic [FAS_DW-1:0]    out_d;
    logic [FAS_IDX_W-1:0] out_idx;
    logic                 out_last;
    logic                 busy;
    logic                 ovf;
    logic                 ovf_clr;

    modport slave (
        input  fft_valid, fft_d, out_ready, ovf_clr,
        output out_valid, out_d, out_idx, out_last, busy, ovf
    );

    modport master (
        output fft_valid, fft_d, out_ready, ovf_clr,
        input  out_valid, out_d, out_idx, out_last, busy, ovf
    );

endinterface

// File: rtl/fft_frame_pts_ctrl.sv
// Frame sequencing for the unloader: IDLE/STREAM FSM, beat counter and sticky overflow.
// A new frame may only be taken while idle or on the very beat that drains the old one.
module fft_frame_pts_ctrl
    import fas_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 fft_valid,
    input  logic                 out_ready,
    input  logic                 ovf_clr,
    output logic                 load,
    output logic [FAS_IDX_W-1:0] cnt,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 ovf
);

    pts_state_t           state_reg, state_next;
    logic [FAS_IDX_W-1:0] cnt_reg, cnt_next;
    logic                 ovf_reg, ovf_next;
    logic                 xfer;
    logic                 last_xfer;
    logic                 load_int;
    logic                 drop;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= PTS_IDLE;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        xfer       = (state_reg == PTS_STREAM) && out_ready;
        last_xfer  = xfer && (cnt_reg == FAS_IDX_W'(FAS_N - 1));
        load_int   = fft_valid && ((state_reg == PTS_IDLE) || last_xfer);
        drop       = fft_valid && (state_reg == PTS_STREAM) && !last_xfer;

        if (load_int) begin
            state_next = PTS_STREAM;
            cnt_next   = '0;
        end else if (xfer) begin
            if (last_xfer) begin
                state_next = PTS_IDLE;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end

        // A dropped frame in the same cycle as a clear must leave the flag set.
        ovf_next = ovf_reg;
        if (drop) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    assign load      = load_int;
    assign cnt       = cnt_reg;
    assign out_valid = (state_reg == PTS_STREAM);
    assign busy      = (state_reg == PTS_STREAM);
    assign ovf       = ovf_reg;

endmodule

// File: rtl/fft_frame_pts.sv
// Parallel-to-serial unloader: captures a 16-word FFT frame and streams it word by word.
// Define PTS_BITREV_EN to read the ports in bit-reversed order (unscrambles a radix-2 DIT core).
module fft_frame_pts
    import fas_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    fft_frame_pts_if.slave  bus
);

    logic                 load;
    logic [FAS_IDX_W-1:0] cnt;
    logic [FAS_IDX_W-1:0] rd_idx;
    logic                 out_valid;
    logic [FAS_DW-1:0]    frame_reg [FAS_N];
    fas_cplx_t            rd_word;

    fft_frame_pts_ctrl u_ctrl (
        .CLK       (CLK),
        .RST       (RST),
        .fft_valid (bus.fft_valid),
        .out_ready (bus.out_ready),
        .ovf_clr   (bus.ovf_clr),
        .load      (load),
        .cnt       (cnt),
        .out_valid (out_valid),
        .busy      (bus.busy),
        .ovf       (bus.ovf)
    );

    // Frame storage carries no reset; only the accepted-load strobe writes it.
    always_ff @(posedge CLK) begin
        if (load) begin
            for (int i = 0; i < FAS_N; i++) begin
                frame_reg[i] <= bus.fft_d[i];
            end
        end
    end

`ifdef PTS_BITREV_EN
    assign rd_idx = fas_bitrev4(cnt);
`else
    assign rd_idx = cnt;
`endif

    assign rd_word = fas_cplx_t'(frame_reg[rd_idx]);

    // Gating with out_valid keeps out_d at zero whenever no word is held, including reset.
    assign bus.out_d     = out_valid ? {rd_word.re, rd_word.im} : '0;
    assign bus.out_idx   = rd_idx;
    assign bus.out_last  = out_valid && (cnt == FAS_IDX_W'(FAS_N - 1));
    assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_fft_frame_pts.sv
// Directed bench for fft_frame_pts: drain, stall, drop/overflow, back-to-back reload,
// asynchronous reset mid-stream and set-versus-clear priority of ovf.
module tb_fft_frame_pts;
    import fas_pkg::*;

    logic CLK;
    logic RST;
    int   checks;
    int   failures;
    int   ord_tab [16];
    logic [31:0] frames [3][16];

    fft_frame_pts_if bus ();

    fft_frame_pts dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int f, input int b);
        return frames[f][ord_tab[b]];
    endfunction

    task automatic load_frame(input int f);
        for (int k = 0; k < 16; k++) bus.fft_d[k] = frames[f][k];
        bus.fft_valid = 1'b1;
        step();
        bus.fft_valid = 1'b0;
        chk_eq("load_latency_valid", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk_eq({tag, "_d"},     bus.out_d,          32'd0);
        chk_eq({tag, "_idx"},   32'(bus.out_idx),   32'd0);
        chk_eq({tag, "_last"},  32'(bus.out_last),  32'd0);
        chk_eq({tag, "_busy"},  32'(bus.busy),      32'd0);
        chk_eq({tag, "_ovf"},   32'(bus.ovf),       32'd0);
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating.
    task automatic run_stream(input int f, input int mode, input int inj_beat, input int inj_f,
                              input bit inj_clr, input int rst_beat);
        int  beat;
        int  cyc;
        bit  rdy;
        bit  injected;
        bit  done;
        beat = 0;
        cyc = 0;
        injected = 1'b0;
        done = 1'b0;
        while (beat < 16 && cyc < 100 && !done) begin
            rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            bus.out_ready = rdy;
            if (beat == rst_beat) begin
                RST = 1'b1;
                #1;
                check_reset_outputs("async_rst");
                step();
                RST = 1'b0;
                done = 1'b1;
            end else begin
                if (beat == inj_beat && !injected) begin
                    for (int k = 0; k < 16; k++) bus.fft_d[k] = frames[inj_f][k];
                    bus.fft_valid = 1'b1;
                    bus.ovf_clr = inj_clr;
                    injected = 1'b1;
                end
                chk_eq("stream_valid", 32'(bus.out_valid), 32'd1);
                chk_eq("stream_busy",  32'(bus.busy),      32'd1);
                chk_eq("stream_d",     bus.out_d,          exp_word(f, beat));
                chk_eq("stream_idx",   32'(bus.out_idx),   32'(ord_tab[beat]));
                chk_eq("stream_last",  32'(bus.out_last),  32'(beat == 15));
                if (rdy) begin
                    $display("beat frame=%0d n=%0d idx=%0d d=%h last=%0b",
                             f, beat, bus.out_idx, bus.out_d, bus.out_last);
                    beat++;
                end
                cyc++;
                step();
                bus.fft_valid = 1'b0;
                bus.ovf_clr = 1'b0;
            end
        end
        bus.out_ready = 1'b0;
        if (!done && beat < 16) chk_eq("stream_budget", 32'(beat), 32'd16);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        failures = 0;
`ifdef PTS_BITREV_EN
        ord_tab = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
        for (int k = 0; k < 16; k++) ord_tab[k] = k;
`endif
        for (int k = 0; k < 16; k++) begin
            frames[0][k] = {16'(k), 16'h8000 + 16'(k)};
            frames[1][k] = {16'h1100 + 16'(k * 17), 16'hFFFF - 16'(k)};
            frames[2][k] = {16'hDEAD, 16'h0F00 + 16'(k)};
        end

        RST = 1'b1;
        bus.fft_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.ovf_clr = 1'b0;
        for (int k = 0; k < 16; k++) bus.fft_d[k] = '0;
        step();
        step();
        check_reset_outputs("reset");
        RST = 1'b0;
        step();

        // 1: full-rate drain
        load_frame(0);
        run_stream(0, 0, -1, 0, 1'b0, -1);
        chk_eq("t1_busy_after", 32'(bus.busy), 32'd0);
        chk_eq("t1_valid_after", 32'(bus.out_valid), 32'd0);
        chk_eq("t1_d_after", bus.out_d, 32'd0);

        // 2: stalled drain
        step();
        load_frame(0);
        run_stream(0, 1, -1, 0, 1'b0, -1);
        chk_eq("t2_busy_after", 32'(bus.busy), 32'd0);

        // 3: drop while streaming, then clear
        load_frame(0);
        run_stream(0, 0, 5, 2, 1'b0, -1);
        chk_eq("t3_ovf_set", 32'(bus.ovf), 32'd1);
        chk_eq("t3_idle_after", 32'(bus.busy), 32'd0);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        chk_eq("t3_ovf_cleared", 32'(bus.ovf), 32'd0);

        // 4: reload on the last-beat transfer
        load_frame(0);
        run_stream(0, 0, 15, 1, 1'b0, -1);
        chk_eq("t4_valid_kept", 32'(bus.out_valid), 32'd1);
        chk_eq("t4_ovf_zero", 32'(bus.ovf), 32'd0);
        run_stream(1, 0, -1, 0, 1'b0, -1);
        chk_eq("t4_busy_after", 32'(bus.busy), 32'd0);

        // 5: asynchronous reset at beat 7, then a fresh frame
        load_frame(0);
        run_stream(0, 0, -1, 0, 1'b0, 7);
        check_reset_outputs("t5_post_rst");
        load_frame(1);
        run_stream(1, 0, -1, 0, 1'b0, -1);
        chk_eq("t5_busy_after", 32'(bus.busy), 32'd0);

        // 6: drop and clear in the same cycle
        load_frame(0);
        run_stream(0, 0, 3, 2, 1'b1, -1);
        chk_eq("t6_ovf_set_wins", 32'(bus.ovf), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
